// File: rtl/line_fetch_sched_pkg.sv
// Shared video timing constants, fetch FSM encoding and line-buffer write record.
// The video timer and the line fetch scheduler both import this package.
package line_fetch_sched_pkg;
  localparam int VID_H_ACTIVE = 1280;
  localparam int VID_H_TOTAL  = 1650;
  localparam int VID_V_ACTIVE = 720;
  localparam int VID_V_TOTAL  = 750;

  localparam int XW    = 11;
  localparam int YW    = 10;
  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic             buf_idx;
    logic [XW-1:0]    addr;
    logic [PIX_W-1:0] data;
  } lb_wr_t;
endpackage

// File: rtl/line_fetch_sched_trig.sv
// Decodes the fetch trigger point (end of active video on a line) and the
// line to prefetch; the last blanking line prefetches line 0 of the next frame.
module fetch_trigger_gen
  import line_fetch_sched_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_TOTAL  = VID_H_TOTAL,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_TOTAL  = VID_V_TOTAL
) (
  input  logic [XW-1:0] counter_x_i,
  input  logic [YW-1:0] counter_y_i,
  output logic          trig_o,
  output logic [YW-1:0] target_line_o
);
  // A timing set with no blanking can never reach the trigger column.
  localparam bit CFG_OK = (H_ACTIVE < H_TOTAL) && (V_ACTIVE < V_TOTAL);

  logic on_x, mid_frame, last_line;

  assign on_x          = counter_x_i == XW'(H_ACTIVE);
  assign mid_frame     = counter_y_i < YW'(V_ACTIVE - 1);
  assign last_line     = counter_y_i == YW'(V_TOTAL - 1);
  assign trig_o        = CFG_OK && on_x && (mid_frame || last_line);
  assign target_line_o = last_line ? '0 : counter_y_i + YW'(1);
endmodule

// File: rtl/line_fetch_sched.sv
// Line prefetch scheduler: issues one line request per trigger, streams the
// returned pixels into a ping-pong line buffer and flags under/overruns.
module line_fetch_sched
  import line_fetch_sched_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_TOTAL  = VID_H_TOTAL,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_TOTAL  = VID_V_TOTAL
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [XW-1:0]    counterX,
  input  logic [YW-1:0]    counterY,
  input  logic             enable,
  input  logic             clr_status,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [YW-1:0]    req_line,
  input  logic             rd_valid,
  input  logic [PIX_W-1:0] rd_data,
  output logic             wr_en,
  output logic             wr_buf,
  output logic [XW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             rd_buf,
  output logic             busy,
  output logic             underrun,
  output logic             overrun
);
  fetch_state_e  state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [YW-1:0] req_line_q, req_line_d;
  logic [XW-1:0] beat_q, beat_d;
  logic          done_valid_q, done_valid_d;
  logic [YW-1:0] done_line_q, done_line_d;
  logic          wr_en_q, wr_en_d;
  lb_wr_t        wr_q, wr_d;
  logic          underrun_q, underrun_d, overrun_q, overrun_d;
  logic          trig, fire, under_set, over_set;
  logic [YW-1:0] target;

  fetch_trigger_gen #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) u_trig (
    .counter_x_i  (counterX),
    .counter_y_i  (counterY),
    .trig_o       (trig),
    .target_line_o(target)
  );

  assign fire = trig && enable;

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_line_d   = req_line_q;
    beat_d       = beat_q;
    done_valid_d = done_valid_q;
    done_line_d  = done_line_q;
    wr_en_d      = 1'b0;
    wr_d         = wr_q;
    case (state_q)
      IDLE: if (fire) begin
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_line_d  = target;
      end
      REQ: if (req_ready) begin
        state_d     = FETCH;
        req_valid_d = 1'b0;
        beat_d      = '0;
      end
      FETCH: if (rd_valid) begin
        wr_en_d = 1'b1;
        wr_d    = '{buf_idx: req_line_q[0], addr: beat_q, data: rd_data};
        beat_d  = beat_q + XW'(1);
        if (beat_q == XW'(H_ACTIVE - 1)) begin
          state_d      = IDLE;
          done_valid_d = 1'b1;
          done_line_d  = req_line_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A line starts displaying at column 0; its pixels must already be in the buffer.
  assign under_set  = (counterX == '0) && (counterY < YW'(V_ACTIVE)) &&
                      !(done_valid_q && (done_line_q == counterY));
  assign over_set   = fire && (state_q != IDLE);
  assign underrun_d = under_set || (underrun_q && !clr_status);
  assign overrun_d  = over_set || (overrun_q && !clr_status);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_line_q   <= '0;
      beat_q       <= '0;
      done_valid_q <= 1'b0;
      done_line_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_q         <= '0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_line_q   <= req_line_d;
      beat_q       <= beat_d;
      done_valid_q <= done_valid_d;
      done_line_q  <= done_line_d;
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_line  = req_line_q;
  assign wr_en     = wr_en_q;
  assign wr_buf    = wr_q.buf_idx;
  assign wr_addr   = wr_q.addr;
  assign wr_data   = wr_q.data;
  assign rd_buf    = counterY[0];
  assign busy      = state_q != IDLE;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
endmodule
